servile_boot_arbiter: RTL and testbench

SERVILE_BOOT_ARBITER -- requirements
Module: servile_boot_arbiter

---
 rtl/servile_boot_pkg.sv | 17 +
 rtl/servile_boot_byte_packer.sv | 37 +++
 rtl/servile_boot_arbiter.sv | 146 ++++++++++++++
 tb/tb_servile_boot_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servile_boot_pkg.sv
// Shared types and constants for the boot loader/arbiter.
// BOOT_VERIFY_EN adds the VERIFY and ERROR states.
package servile_boot_pkg;

  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_WRITE,
`ifdef BOOT_VERIFY_EN
    ST_VERIFY,
    ST_ERROR,
`endif
    ST_DONE
  } state_e;

endpackage

// File: rtl/servile_boot_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word. The word is valid
// in the same cycle the 4th byte is accepted, so the loader can latch it at once.
module servile_boot_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (accept_i) begin
      cnt_q <= cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    data_q[7:0]   <= byte_i;
        2'd1:    data_q[15:8]  <= byte_i;
        2'd2:    data_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  // The last byte bypasses storage and goes straight into bits 31:24.
  assign word_o  = {byte_i, data_q};
  assign valid_o = accept_i && (cnt_q == 2'd3);

endmodule

// File: rtl/servile_boot_arbiter.sv
// Boot loader: streams bytes into SRAM words, then hands the bus to the CPU.
// Define BOOT_VERIFY_EN to read back each word and halt on mismatch.
module servile_boot_arbiter
  import servile_boot_pkg::*;
#(
  parameter int aw    = 8,
  parameter int words = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_ld_data,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  input  logic [aw-3:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_dat,
  input  logic [3:0]    i_cpu_sel,
  input  logic          i_cpu_we,
  input  logic          i_cpu_stb,
  output logic [31:0]   o_cpu_rdt,
  output logic          o_cpu_ack,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic          o_err
);

  localparam int CW = $clog2(words) + 1;
  localparam logic [CW-1:0] LAST = CW'(words - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   dat_q;
  logic          stb_q, we_q, ld_ready_q, cpu_rst_q, done_q, err_q;
  logic          accept, word_valid, advance;
  logic [31:0]   word;
  logic [aw-3:0] adr_ld;

  assign accept = i_ld_valid && ld_ready_q;

  servile_boot_byte_packer u_packer (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clear_i  (state_q != ST_COLLECT),
    .byte_i   (i_ld_data),
    .accept_i (accept),
    .word_o   (word),
    .valid_o  (word_valid)
  );

  // advance marks the ack that completes a word and moves to the next one.
  always_comb begin
    advance = 1'b0;
`ifdef BOOT_VERIFY_EN
    advance = i_wb_ack && (state_q == ST_VERIFY) && (i_wb_rdt == dat_q);
`else
    advance = i_wb_ack && (state_q == ST_WRITE);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= '0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          ld_ready_q <= 1'b1;
          if (word_valid) begin
            ld_ready_q <= 1'b0;
            dat_q      <= word;
            stb_q      <= 1'b1;
            we_q       <= 1'b1;
            state_q    <= ST_WRITE;
          end
        end
`ifdef BOOT_VERIFY_EN
        ST_WRITE: begin
          if (i_wb_ack) begin
            we_q    <= 1'b0;
            state_q <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (i_wb_ack && (i_wb_rdt != dat_q)) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERROR;
          end
        end
        ST_ERROR: ;
`else
        ST_WRITE: ;
`endif
        ST_DONE: ;
        default: state_q <= ST_COLLECT;
      endcase
      if (advance) begin
        stb_q <= 1'b0;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_q   <= ST_DONE;
          done_q    <= 1'b1;
          cpu_rst_q <= 1'b0;
        end else begin
          state_q    <= ST_COLLECT;
          ld_ready_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    adr_ld         = '0;
    adr_ld[CW-1:0] = cnt_q;
  end

  assign o_wb_adr   = done_q ? i_cpu_adr : adr_ld;
  assign o_wb_dat   = done_q ? i_cpu_dat : dat_q;
  assign o_wb_sel   = done_q ? i_cpu_sel : SEL_ALL;
  assign o_wb_we    = done_q ? i_cpu_we  : we_q;
  assign o_wb_stb   = done_q ? i_cpu_stb : stb_q;
  assign o_cpu_ack  = done_q & i_wb_ack;
  assign o_cpu_rdt  = i_wb_rdt;
  assign o_ld_ready = ld_ready_q;
  assign o_cpu_rst  = cpu_rst_q;
  assign o_done     = done_q;
`ifdef BOOT_VERIFY_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_servile_boot_arbiter.sv
// Scoreboard bench for servile_boot_arbiter with words=2.
// Define BOOT_VERIFY_EN to also exercise readback verification.
module tb_servile_boot_arbiter;

  localparam int AW    = 8;
  localparam int WORDS = 2;
`ifdef BOOT_VERIFY_EN
  localparam bit FINAL_WE = 1'b0;
`else
  localparam bit FINAL_WE = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    ld_data;
  logic          ld_valid, ld_ready;
  logic [AW-3:0] cpu_adr, wb_adr;
  logic [31:0]   cpu_dat, cpu_rdt, wb_dat, wb_rdt;
  logic [3:0]    cpu_sel, wb_sel;
  logic          cpu_we, cpu_stb, cpu_ack, wb_we, wb_stb, wb_ack;
  logic          cpu_rst, done, err;

  logic          resp_ack, cpu_ack_drv;
  logic [31:0]   resp_rdt, cpu_rdt_drv;
  assign wb_ack = resp_ack | cpu_ack_drv;
  assign wb_rdt = done ? cpu_rdt_drv : resp_rdt;

  servile_boot_arbiter #(.aw(AW), .words(WORDS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ld_data(ld_data), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel),
    .i_cpu_we(cpu_we), .i_cpu_stb(cpu_stb),
    .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
    .o_wb_we(wb_we), .o_wb_stb(wb_stb), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_cpu_rst(cpu_rst), .o_done(done), .o_err(err)
  );

  typedef struct {
    logic [AW-3:0] adr;
    logic [31:0]   dat;
  } wr_t;

  wr_t           exp_q[$];
  logic [31:0]   mem [0:63];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            nwrites = 0;
  int            widx    = 0;
  int            ack_delay = 3;
  bit            corrupt = 1'b0;
  logic [AW-3:0] last_wr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Models the SRAM arbiter during load: scores writes, answers readbacks.
  initial begin : responder
    logic [AW-3:0] a;
    logic [31:0]   d;
    logic          w;
    logic          last;
    wr_t           e;
    resp_ack = 1'b0;
    resp_rdt = '0;
    forever begin
      @(negedge clk);
      if (rst_n && wb_stb && !done) begin
        a = wb_adr; d = wb_dat; w = wb_we;
        check("sel_ld", {28'd0, wb_sel}, 32'hF);
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          check("stb_hold", {31'd0, wb_stb}, 32'd1);
          check("adr_hold", {26'd0, wb_adr}, {26'd0, a});
          check("dat_hold", wb_dat, d);
          check("we_hold", {31'd0, wb_we}, {31'd0, w});
          check("rdy_low", {31'd0, ld_ready}, 32'd0);
        end
        if (w) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_adr", {26'd0, a}, {26'd0, e.adr});
            check("wr_dat", d, e.dat);
          end
          mem[a]  = d;
          last_wr = a;
          nwrites++;
        end else begin
          check("rd_adr", {26'd0, a}, {26'd0, last_wr});
          resp_rdt = corrupt ? (mem[a] ^ 32'd1) : mem[a];
        end
        resp_ack = 1'b1;
        #1 check("cpu_ack_ld", {31'd0, cpu_ack}, 32'd0);
        @(negedge clk);
        resp_ack = 1'b0;
        last = (int'(a) == WORDS - 1) && (w == FINAL_WE);
        if (!corrupt) begin
          check("done_after_ack", {31'd0, done}, {31'd0, last});
          check("cpu_rst_after_ack", {31'd0, cpu_rst}, {31'd0, !last});
        end
      end
    end
  end

  // Called at a negedge; leaves ld_valid high so the next byte waits on ready.
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    ld_data  = b;
    ld_valid = 1'b1;
    while (!ld_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!ld_ready) check("ld_timeout", 32'd0, 32'd1);
    else check("stb_collect", {31'd0, wb_stb}, 32'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    wr_t e;
    e.adr = widx[AW-3:0];
    e.dat = w;
    exp_q.push_back(e);
    widx++;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!done && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    ld_valid = 1'b0; ld_data = '0;
    cpu_adr = '1; cpu_dat = 32'hDEADBEEF; cpu_sel = 4'h3; cpu_we = 1'b1; cpu_stb = 1'b1;
    cpu_ack_drv = 1'b0; cpu_rdt_drv = '0;

    #12;
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", {31'd0, ld_ready}, 32'd1);

`ifndef BOOT_VERIFY_EN
    // Basic load with slow acks while the CPU is requesting.
    send_word(32'h44332211);
    send_word(32'h88776655);
    ld_valid = 1'b0;
    wait_done();
    check("q_empty", exp_q.size(), 32'd0);
    check("nwrites", nwrites, 32'd2);
    check("err_tied", {31'd0, err}, 32'd0);

    ld_valid = 1'b1; ld_data = 8'h99;
    repeat (6) @(negedge clk);
    check("rdy_in_done", {31'd0, ld_ready}, 32'd0);
    check("no_extra_wr", nwrites, 32'd2);
    ld_valid = 1'b0;

    cpu_adr = 6'd1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_stb = 1'b1;
    cpu_rdt_drv = mem[1];
    #1;
    check("cpu_rd_adr", {26'd0, wb_adr}, 32'd1);
    check("cpu_rd_we", {31'd0, wb_we}, 32'd0);
    check("cpu_rd_stb", {31'd0, wb_stb}, 32'd1);
    check("cpu_ack_wait", {31'd0, cpu_ack}, 32'd0);
    cpu_ack_drv = 1'b1;
    #1;
    check("cpu_ack", {31'd0, cpu_ack}, 32'd1);
    check("cpu_rdt", cpu_rdt, 32'h88776655);
    @(negedge clk);
    cpu_ack_drv = 1'b0;
    cpu_adr = 6'd5; cpu_dat = 32'hCAFEF00D; cpu_sel = 4'h6; cpu_we = 1'b1;
    #1;
    check("cpu_wr_adr", {26'd0, wb_adr}, 32'd5);
    check("cpu_wr_dat", wb_dat, 32'hCAFEF00D);
    check("cpu_wr_sel", {28'd0, wb_sel}, 32'h6);
    check("cpu_wr_we", {31'd0, wb_we}, 32'd1);
    cpu_stb = 1'b0;
    #1 check("cpu_stb_low", {31'd0, wb_stb}, 32'd0);
    cpu_stb = 1'b1; cpu_adr = '1;

    // Reset part-way through the second word; the restart must begin at word 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nwrites = 0; widx = 0; ack_delay = 0;
    send_word(32'h04030201);
    send_byte(8'h05);
    send_byte(8'h06);
    ld_valid = 1'b0;
    check("adr_pre_rst", {26'd0, wb_adr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("mid_rst_adr", {26'd0, wb_adr}, 32'd0);
    check("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nwrites = 0; widx = 0; ack_delay = 1;
    send_word(32'hDDCCBBAA);
    send_word(32'h11223344);
    ld_valid = 1'b0;
    wait_done();
    check("restart_nwrites", nwrites, 32'd2);
    check("restart_mem0", mem[0], 32'hDDCCBBAA);
`else
    // Clean verified load, then a corrupted readback of word 0.
    send_word(32'h44332211);
    send_word(32'h88776655);
    ld_valid = 1'b0;
    wait_done();
    check("v_nwrites", nwrites, 32'd2);
    check("v_err_clean", {31'd0, err}, 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nwrites = 0; widx = 0; corrupt = 1'b1;
    send_word(32'h44332211);
    ld_valid = 1'b1; ld_data = 8'h55;
    repeat (20) @(negedge clk);
    check("v_err", {31'd0, err}, 32'd1);
    check("v_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("v_err_done", {31'd0, done}, 32'd0);
    check("v_err_ready", {31'd0, ld_ready}, 32'd0);
    check("v_err_stb", {31'd0, wb_stb}, 32'd0);
    check("v_err_nwrites", nwrites, 32'd1);
    ld_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
